// File: rtl/bubble_buffer_loader_if.sv
// Loader-side bus bundle: flash read request, byte stream from the SPI engine and the bubble out-buffer write port.
// master = loader, slave = SPI engine / buffer side.
interface bubble_buffer_loader_if;
    // Byte stream: a byte moves on a rising MCLK edge where IN_VALID and IN_READY are both high.
    logic        FLASH_REQ;
    logic [19:0] FLASH_ADDR;
    logic [7:0]  IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic        nOUTBUFWRCLKEN;
    logic [14:0] OUTBUFWRADDR;
    logic        OUTBUFWRDATA;
    logic [2:0]  DBG_STATE;

    modport master (
        output FLASH_REQ, FLASH_ADDR, IN_READY,
        output nOUTBUFWRCLKEN, OUTBUFWRADDR, OUTBUFWRDATA, DBG_STATE,
        input  IN_DATA, IN_VALID
    );

    modport slave (
        input  FLASH_REQ, FLASH_ADDR, IN_READY,
        input  nOUTBUFWRCLKEN, OUTBUFWRADDR, OUTBUFWRDATA, DBG_STATE,
        output IN_DATA, IN_VALID
    );
endinterface

// File: rtl/bubble_buffer_loader.sv
// Write-side sequencer for the bubble out buffer: flash request, byte intake, MSB-first bit writes.
// Optional payload checksum is enabled by defining BBUF_LOADER_CHKSUM_EN.
module bubble_buffer_loader #(
    parameter int          BOOT_BYTES      = 482,
    parameter int          PAGE_BYTES      = 146,
    parameter int          PAGE_PAD_WORDS  = 3,
    parameter int          USER_BASE_WORD  = 7168,
    parameter logic [19:0] BOOT_FLASH_BASE = 20'h00000,
    parameter logic [19:0] PAGE_FLASH_BASE = 20'h01000,
    parameter int          PAGE_STRIDE     = 256
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        BITWIDTH4,
    input  logic [2:0]  ACCTYPE,
    input  logic        LOAD_START,
    input  logic        LOAD_BOOT,
    input  logic [10:0] LOAD_PAGE,
    input  logic        ABORT,
    output logic        BUSY,
    output logic        LOAD_DONE,
`ifdef BBUF_LOADER_CHKSUM_EN
    output logic [7:0]  CHKSUM,
    input  logic [7:0]  CHKSUM_EXP,
    output logic        CHKSUM_OK,
`endif
    bubble_buffer_loader_if.master bus
);

    localparam int MAX_BYTES = (BOOT_BYTES > PAGE_BYTES) ? BOOT_BYTES : PAGE_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);
    localparam int PAD_W     = $clog2(PAGE_PAD_WORDS * 4 + 1);

    localparam logic [PAD_W-1:0] PAD_BITS_2 = PAD_W'(PAGE_PAD_WORDS * 2);
    localparam logic [PAD_W-1:0] PAD_BITS_4 = PAD_W'(PAGE_PAD_WORDS * 4);
    localparam logic [14:0]      USER_ADDR_2 = 15'(USER_BASE_WORD << 1);
    localparam logic [14:0]      USER_ADDR_4 = 15'(USER_BASE_WORD << 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_PAD   = 3'd2,
        S_FETCH = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q;
    logic [7:0]        byte_q;
    logic [2:0]        bit_q;
    logic [CNT_W-1:0]  bytes_left_q;
    logic [PAD_W-1:0]  pad_left_q;
    logic [14:0]       addr_q;

    logic              flash_req_q;
    logic [19:0]       flash_addr_q;
    logic              in_ready_q;
    logic              wr_n_q;
    logic [14:0]       wr_addr_q;
    logic              wr_data_q;
    logic              busy_q;
    logic              done_q;

    logic              gate_open;
    logic              start_ok;
    logic              accept;
    logic [19:0]       page_flash_addr;
    logic              unused_acctype;

    assign gate_open       = ACCTYPE[1];
    assign unused_acctype  = ^{ACCTYPE[2], ACCTYPE[0]};
    assign start_ok        = (state_q == S_IDLE) && LOAD_START && !ABORT;
    assign accept          = (state_q == S_FETCH) && in_ready_q && bus.IN_VALID && !ABORT;
    assign page_flash_addr = PAGE_FLASH_BASE + 20'(LOAD_PAGE) * 20'(PAGE_STRIDE);

    // addr_q is the address of the next bit to write; it stands still while the gate is closed,
    // so a stall never drops or repeats a bit.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            byte_q       <= '0;
            bit_q        <= '0;
            bytes_left_q <= '0;
            pad_left_q   <= '0;
            addr_q       <= '0;
            flash_req_q  <= 1'b0;
            flash_addr_q <= '0;
            in_ready_q   <= 1'b0;
            wr_n_q       <= 1'b1;
            wr_addr_q    <= '0;
            wr_data_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            flash_req_q <= 1'b0;
            wr_n_q      <= 1'b1;
            done_q      <= 1'b0;

            if (ABORT && (state_q != S_IDLE)) begin
                state_q    <= S_IDLE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start_ok) begin
                            state_q     <= S_REQ;
                            flash_req_q <= 1'b1;
                            busy_q      <= 1'b1;
                            if (LOAD_BOOT) begin
                                flash_addr_q <= BOOT_FLASH_BASE;
                                addr_q       <= '0;
                                pad_left_q   <= '0;
                                bytes_left_q <= CNT_W'(BOOT_BYTES);
                            end else begin
                                flash_addr_q <= page_flash_addr;
                                addr_q       <= BITWIDTH4 ? USER_ADDR_4 : USER_ADDR_2;
                                pad_left_q   <= BITWIDTH4 ? PAD_BITS_4 : PAD_BITS_2;
                                bytes_left_q <= CNT_W'(PAGE_BYTES);
                            end
                        end
                    end

                    S_REQ: begin
                        if (pad_left_q == '0) begin
                            state_q    <= S_FETCH;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_PAD;
                        end
                    end

                    S_PAD: begin
                        if (gate_open) begin
                            wr_n_q     <= 1'b0;
                            wr_addr_q  <= addr_q;
                            wr_data_q  <= 1'b0;
                            addr_q     <= addr_q + 15'd1;
                            pad_left_q <= pad_left_q - PAD_W'(1);
                            if (pad_left_q == PAD_W'(1)) begin
                                state_q    <= S_FETCH;
                                in_ready_q <= 1'b1;
                            end
                        end
                    end

                    S_FETCH: begin
                        if (accept) begin
                            byte_q       <= bus.IN_DATA;
                            bit_q        <= '0;
                            bytes_left_q <= bytes_left_q - CNT_W'(1);
                            in_ready_q   <= 1'b0;
                            state_q      <= S_SHIFT;
                        end
                    end

                    S_SHIFT: begin
                        if (gate_open) begin
                            wr_n_q    <= 1'b0;
                            wr_addr_q <= addr_q;
                            wr_data_q <= byte_q[3'd7 - bit_q];
                            addr_q    <= addr_q + 15'd1;
                            bit_q     <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                if (bytes_left_q == '0) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q    <= S_FETCH;
                                    in_ready_q <= 1'b1;
                                end
                            end
                        end
                    end

                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end

                    default: begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BBUF_LOADER_CHKSUM_EN
    logic [7:0] chksum_q;

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            chksum_q <= '0;
        end else if (start_ok) begin
            chksum_q <= '0;
        end else if (accept) begin
            chksum_q <= chksum_q + bus.IN_DATA;
        end
    end

    assign CHKSUM    = chksum_q;
    assign CHKSUM_OK = (chksum_q == CHKSUM_EXP);
`endif

    assign bus.FLASH_REQ      = flash_req_q;
    assign bus.FLASH_ADDR     = flash_addr_q;
    assign bus.IN_READY       = in_ready_q;
    assign bus.nOUTBUFWRCLKEN = wr_n_q;
    assign bus.OUTBUFWRADDR   = wr_addr_q;
    assign bus.OUTBUFWRDATA   = wr_data_q;
    assign bus.DBG_STATE      = state_q;
    assign BUSY               = busy_q;
    assign LOAD_DONE          = done_q;

endmodule

// File: tb/tb_bubble_buffer_loader.sv
// Bench for bubble_buffer_loader: a queue of expected (address, bit) writes built from the load rules,
// checked against every buffer strobe, with randomized stream gaps, write-gate stalls, aborts and resets.
module tb_bubble_buffer_loader;

    localparam int BOOT_BYTES = 482;
    localparam int PAGE_BYTES = 146;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        BITWIDTH4;
    logic [2:0]  ACCTYPE;
    logic        LOAD_START;
    logic        LOAD_BOOT;
    logic [10:0] LOAD_PAGE;
    logic        ABORT;
    logic        BUSY;
    logic        LOAD_DONE;
`ifdef BBUF_LOADER_CHKSUM_EN
    logic [7:0]  CHKSUM;
    logic [7:0]  CHKSUM_EXP;
    logic        CHKSUM_OK;
`endif

    bubble_buffer_loader_if bus ();

    bubble_buffer_loader dut (
        .MCLK       (MCLK),
        .RESET      (RESET),
        .BITWIDTH4  (BITWIDTH4),
        .ACCTYPE    (ACCTYPE),
        .LOAD_START (LOAD_START),
        .LOAD_BOOT  (LOAD_BOOT),
        .LOAD_PAGE  (LOAD_PAGE),
        .ABORT      (ABORT),
        .BUSY       (BUSY),
        .LOAD_DONE  (LOAD_DONE),
`ifdef BBUF_LOADER_CHKSUM_EN
        .CHKSUM     (CHKSUM),
        .CHKSUM_EXP (CHKSUM_EXP),
        .CHKSUM_OK  (CHKSUM_OK),
`endif
        .bus        (bus)
    );

    // ---------------- clock ----------------
    always #10 MCLK = ~MCLK;

    // ---------------- model state ----------------
    logic [7:0]  byte_mem [0:BOOT_BYTES-1];
    logic [15:0] exp_q [$];          // {address, bit} in write order
    logic [19:0] exp_flash;
    logic [7:0]  exp_sum;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    int          done_cnt = 0;
    bit          flash_pending = 1'b0;
    bit          done_allowed = 1'b1;
    bit          gate_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < BOOT_BYTES; i++) byte_mem[i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < BOOT_BYTES; i++) byte_mem[i] = 8'($urandom);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < BOOT_BYTES; i++) byte_mem[i] = v;
    endtask

    // Expected write list straight from the region rules: pad zeros, then payload bytes MSB first.
    task automatic build_expect(input bit boot, input bit wide, input logic [10:0] page);
        int base;
        int pad;
        int nbytes;
        exp_q.delete();
        exp_sum = 8'h00;
        if (boot) begin
            base = 0; pad = 0; nbytes = BOOT_BYTES;
            exp_flash = 20'h00000;
        end else begin
            base = wide ? 7168 * 4 : 7168 * 2;
            pad = wide ? 12 : 6;
            nbytes = PAGE_BYTES;
            exp_flash = 20'(32'h01000 + 32'(page) * 256);
        end
        for (int i = 0; i < pad; i++) exp_q.push_back({15'(base + i), 1'b0});
        for (int b = 0; b < nbytes; b++) begin
            exp_sum = exp_sum + byte_mem[b];
            for (int j = 0; j < 8; j++)
                exp_q.push_back({15'(base + pad + b * 8 + j), byte_mem[b][7 - j]});
        end
`ifdef BBUF_LOADER_CHKSUM_EN
        CHKSUM_EXP = ($urandom_range(0, 1) == 1) ? exp_sum : 8'($urandom);
`endif
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge MCLK) begin
        logic [15:0] e;
        if (bus.nOUTBUFWRCLKEN === 1'b0) begin
            n_writes++;
            check("gate_open_before_strobe", 32'(gate_prev), 32'd1);
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.OUTBUFWRADDR), 32'(e[15:1]));
                check("write_data", 32'(bus.OUTBUFWRDATA), 32'(e[0]));
            end
        end
        if (bus.FLASH_REQ === 1'b1) begin
            check("flash_req_expected", 32'(flash_pending), 32'd1);
            check("flash_addr", 32'(bus.FLASH_ADDR), 32'(exp_flash));
            flash_pending = 1'b0;
        end
        if (LOAD_DONE === 1'b1) begin
            done_cnt++;
            check("done_allowed", 32'(done_allowed), 32'd1);
            check("writes_left_at_done", 32'(exp_q.size()), 32'd0);
            check("busy_at_done", 32'(BUSY), 32'd1);
`ifdef BBUF_LOADER_CHKSUM_EN
            check("chksum", 32'(CHKSUM), 32'(exp_sum));
            check("chksum_ok", 32'(CHKSUM_OK), 32'(exp_sum == CHKSUM_EXP));
`endif
        end
        if (bus.IN_READY === 1'b1) check("ready_only_while_busy", 32'(BUSY), 32'd1);
        gate_prev = ACCTYPE[1];
    end

    // ---------------- driver tasks ----------------
    task automatic start_load(input bit boot, input bit wide, input logic [10:0] page);
        build_expect(boot, wide, page);
        flash_pending = 1'b1;
        @(posedge MCLK); #1;
        LOAD_START = 1'b1; LOAD_BOOT = boot; BITWIDTH4 = wide; LOAD_PAGE = page;
        @(posedge MCLK); #1;
        LOAD_START = 1'b0;
    endtask

    task automatic interrupt(input bit is_reset);
        done_allowed = 1'b0;
        if (is_reset) RESET = 1'b1; else ABORT = 1'b1;
        bus.IN_VALID = 1'b0;
        LOAD_START = 1'b0;
        @(posedge MCLK); #1;
        RESET = 1'b0; ABORT = 1'b0;
        exp_q.delete();
        @(negedge MCLK);
        check("busy_after_interrupt", 32'(BUSY), 32'd0);
        check("strobe_after_interrupt", 32'(bus.nOUTBUFWRCLKEN), 32'd1);
        check("ready_after_interrupt", 32'(bus.IN_READY), 32'd0);
        check("done_after_interrupt", 32'(LOAD_DONE), 32'd0);
        repeat (20) @(posedge MCLK);
        #1;
        check("still_idle_after_interrupt", 32'(BUSY), 32'd0);
        done_allowed = 1'b1;
    endtask

    // vmode: 0 always valid, 1 valid every 4th cycle, 2 random. gmode: 0 open, 1 closed 10 cycles, 2 random.
    task automatic run_stream(input int vmode, input int gmode, input int stall_at, input int abort_bytes,
                              input int reset_bytes, input bit sneak, output int cycles);
        int idx;
        int cyc;
        int start_done;
        int w0;
        int hit;
        int total;
        bit fire;
        logic [2:0] base_acc;
        idx = 0; cyc = 0; hit = -1;
        start_done = done_cnt; w0 = n_writes; total = exp_q.size(); base_acc = ACCTYPE;
        bus.IN_DATA = byte_mem[0];
        bus.IN_VALID = (vmode == 0);
        while (done_cnt == start_done && cyc < 30000) begin
            @(negedge MCLK);
            fire = bus.IN_VALID && bus.IN_READY;
            @(posedge MCLK); #1;
            cyc++;
            if (fire) idx++;
            LOAD_START = 1'b0;
            if (sneak && cyc == 30) begin
                LOAD_START = 1'b1;
                LOAD_BOOT = 1'($urandom_range(0, 1));
                LOAD_PAGE = 11'($urandom_range(0, 2047));
            end
            if (abort_bytes > 0 && idx == abort_bytes) begin
                interrupt(1'b0);
                cycles = cyc;
                return;
            end
            if (reset_bytes > 0 && idx == reset_bytes && hit < 0) hit = cyc + 3;
            if (cyc == hit) begin
                interrupt(1'b1);
                cycles = cyc;
                return;
            end
            case (vmode)
                0:       bus.IN_VALID = 1'b1;
                1:       bus.IN_VALID = ((cyc % 4) == 0);
                default: bus.IN_VALID = 1'($urandom_range(0, 1));
            endcase
            bus.IN_DATA = (idx < BOOT_BYTES) ? byte_mem[idx] : 8'h00;
            case (gmode)
                0:       ACCTYPE = base_acc;
                1:       ACCTYPE = (cyc >= stall_at && cyc < stall_at + 10) ? 3'b000 : base_acc;
                default: ACCTYPE = {1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1))};
            endcase
        end
        bus.IN_VALID = 1'b0;
        LOAD_START = 1'b0;
        ACCTYPE = base_acc;
        cycles = cyc;
        check("load_completed", 32'(done_cnt - start_done), 32'd1);
        check("write_count", 32'(n_writes - w0), 32'(total));
        repeat (2) @(posedge MCLK);
        #1;
        check("idle_after_done", 32'(BUSY), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        logic [10:0] pg;
        RESET = 1'b1; ABORT = 1'b0; LOAD_START = 1'b0; LOAD_BOOT = 1'b0; LOAD_PAGE = '0;
        BITWIDTH4 = 1'b0; ACCTYPE = 3'b110; bus.IN_VALID = 1'b0; bus.IN_DATA = 8'h00;
`ifdef BBUF_LOADER_CHKSUM_EN
        CHKSUM_EXP = 8'h00;
`endif
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        check("rst_flash_req", 32'(bus.FLASH_REQ), 32'd0);
        check("rst_flash_addr", 32'(bus.FLASH_ADDR), 32'd0);
        check("rst_in_ready", 32'(bus.IN_READY), 32'd0);
        check("rst_wr_n", 32'(bus.nOUTBUFWRCLKEN), 32'd1);
        check("rst_wr_addr", 32'(bus.OUTBUFWRADDR), 32'd0);
        check("rst_wr_data", 32'(bus.OUTBUFWRDATA), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(LOAD_DONE), 32'd0);
        @(posedge MCLK); #1;
        RESET = 1'b0;

        // Bootloader, 2bit, ramp bytes, stream always valid.
        fill_ramp();
        ACCTYPE = 3'b110;
        build_expect(1'b1, 1'b0, 11'd0);
        check("pin_boot_len", 32'(exp_q.size()), 32'd3856);
        check("pin_boot_first", 32'(exp_q[0]), 32'h0000);
        check("pin_boot_bit7_zero", 32'(exp_q[7][0]), 32'd0);
        check("pin_boot_byte1_lsb", 32'(exp_q[15]), 32'((15 << 1) | 1));
        check("pin_boot_last", 32'(exp_q[3855]), 32'((3855 << 1) | 1));
        start_load(1'b1, 1'b0, 11'd0);
        run_stream(0, 0, 0, 0, 0, 1'b0, cyc);
        // 1 REQ cycle + 9 cycles per byte, LOAD_DONE seen one cycle before the loop exits.
        check("boot_cycles", 32'(cyc), 32'd4340);

        // User page 5, 2bit, with an ignored LOAD_START mid-load.
        fill_random();
        ACCTYPE = 3'b111;
        build_expect(1'b0, 1'b0, 11'd5);
        check("pin_page5_flash", 32'(exp_flash), 32'h01500);
        check("pin_page5_len", 32'(exp_q.size()), 32'd1174);
        check("pin_page5_pad0", 32'(exp_q[0]), 32'(14336 << 1));
        check("pin_page5_pad5", 32'(exp_q[5]), 32'(14341 << 1));
        check("pin_page5_payload", 32'(exp_q[6][15:1]), 32'd14342);
        check("pin_page5_last", 32'(exp_q[1173][15:1]), 32'd15509);
        start_load(1'b0, 1'b0, 11'd5);
        run_stream(0, 0, 0, 0, 0, 1'b1, cyc);

        // User page, 4bit, valid every 4th cycle.
        fill_random();
        pg = 11'($urandom_range(0, 2047));
        build_expect(1'b0, 1'b1, pg);
        check("pin_4bit_pad0", 32'(exp_q[0]), 32'(28672 << 1));
        check("pin_4bit_pad11", 32'(exp_q[11]), 32'(28683 << 1));
        check("pin_4bit_payload", 32'(exp_q[12][15:1]), 32'd28684);
        check("pin_4bit_last", 32'(exp_q[1179][15:1]), 32'd29851);
        start_load(1'b0, 1'b1, pg);
        run_stream(1, 0, 0, 0, 0, 1'b0, cyc);

        // Write gate closed for 10 cycles mid-load.
        fill_random();
        ACCTYPE = 3'b110;
        start_load(1'b0, 1'b0, 11'd17);
        run_stream(0, 1, 40, 0, 0, 1'b0, cyc);

        // Abort after 3 bytes, then reset in the middle of a byte.
        fill_random();
        start_load(1'b1, 1'b0, 11'd0);
        run_stream(0, 0, 0, 3, 0, 1'b0, cyc);
        start_load(1'b0, 1'b1, 11'd9);
        run_stream(0, 0, 0, 0, 2, 1'b0, cyc);

        // ABORT together with LOAD_START in IDLE: nothing starts.
        flash_pending = 1'b0;
        exp_q.delete();
        @(posedge MCLK); #1;
        LOAD_START = 1'b1; ABORT = 1'b1; LOAD_BOOT = 1'b1;
        @(posedge MCLK); #1;
        LOAD_START = 1'b0; ABORT = 1'b0;
        repeat (5) @(posedge MCLK);
        #1;
        check("abort_beats_start", 32'(BUSY), 32'd0);

`ifdef BBUF_LOADER_CHKSUM_EN
        fill_const(8'h01);
        build_expect(1'b0, 1'b0, 11'd0);
        check("pin_chksum_ones", 32'(exp_sum), 32'h92);
        start_load(1'b0, 1'b0, 11'd0);
        CHKSUM_EXP = 8'h92;
        run_stream(0, 0, 0, 0, 0, 1'b0, cyc);
`endif

        // Randomized loads: random gaps and gate closures.
        for (int n = 0; n < 6; n++) begin
            bit boot;
            bit wide;
            boot = (n == 2);
            wide = 1'($urandom_range(0, 1));
            pg = 11'($urandom_range(0, 2047));
            fill_random();
            ACCTYPE = 3'b110;
            start_load(boot, wide, pg);
            run_stream(2, 2, 0, 0, 0, 1'($urandom_range(0, 1)), cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
